alu_cmd_issuer: RTL and testbench

//  Initiator side of the 4-bit ALU (alg) interface. Queues operand/opcode commands in a FIFO,

---
 rtl/alu_pkg.sv | 25 ++
 rtl/cmd_fifo.sv | 49 ++++
 rtl/alu_cmd_issuer.sv | 140 ++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer.
// Opcodes follow the 4-bit ALU encoding; results come back 8 bits wide.
package alu_pkg;

  localparam int ALU_W = 4;
  localparam int RES_W = 8;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd4;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd5;
  localparam logic [OP_W-1:0] OP_MULT = 3'd6;
  localparam logic [OP_W-1:0] OP_DIV  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; one extra pointer bit separates full from empty.
// Head data is read straight from storage, so a pop consumes the entry shown this cycle.
module cmd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, holds operands on the ALU for SETTLE cycles, then returns results in order.
// IDLE: wait/pop | DRIVE: operands settling | CAPTURE: latch result | RESP: wait for consumer
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  input  logic [OP_W-1:0]  cmd_op,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [RES_W-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic [OP_W-1:0]  rsp_op,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CMD_W = OP_W + 2 * ALU_W;
  localparam int CNT_W = $clog2(SETTLE + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ALU_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d, rsp_op_q, rsp_op_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

  logic               fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CMD_W-1:0]   fifo_head;

  assign fifo_push = cmd_valid && !fifo_full;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cmd_op, cmd_a, cmd_b}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_op_d    = rsp_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop                    = 1'b1;
          {alu_op_d, alu_a_d, alu_b_d} = fifo_head;
          cnt_d                       = CNT_W'(SETTLE);
          state_d                     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // The counter value is the number of DRIVE cycles still to come, this one included.
        if (cnt_q == CNT_W'(1)) state_d = ST_CAPTURE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_op_d    = alu_op_q;
        if (alu_op_q == OP_DIV && alu_b_q == '0) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_op_q    <= rsp_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: SETTLE=1 instance scoreboarded against an in-order result model,
// SETTLE=3 instance for settle timing and mid-operation reset.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic       cv, cr, rv, rr, re, busy;
  logic [3:0] ca, cb, aa, ab;
  logic [2:0] cop, aop, ro;
  logic [7:0] ares, rd;
  // SETTLE=3 instance
  logic       cv3, cr3, rv3, rr3, re3, busy3;
  logic [3:0] ca3, cb3, aa3, ab3;
  logic [2:0] cop3, aop3, ro3;
  logic [7:0] ares3, rd3;

  int errs = 0;
  int checks = 0;
  int n_acc = 0;
  int n_rsp = 0;
  bit hs_last = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] op;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  // Bench stand-in for the combinational ALU.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: alu_f = {4'h0, a & b};
      3'd1: alu_f = {4'h0, a | b};
      3'd2: alu_f = {4'h0, ~(a & b)};
      3'd3: alu_f = {4'h0, a ^ b};
      3'd4: alu_f = {4'h0, a} + {4'h0, b};
      3'd5: alu_f = {4'h0, a} - {4'h0, b};
      3'd6: alu_f = {4'h0, a} * {4'h0, b};
      default: alu_f = (b == 4'h0) ? 8'hA5 : {4'h0, a} / {4'h0, b};
    endcase
  endfunction

  assign ares  = alu_f(aop, aa, ab);
  assign ares3 = alu_f(aop3, aa3, ab3);

  // Expected response for a command, from integer arithmetic.
  function automatic exp_t make_exp(input logic [2:0] op, input logic [3:0] a4, input logic [3:0] b4);
    int a, b, r;
    exp_t e;
    a = int'(a4);
    b = int'(b4);
    e.err = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = 15 - (a & b);
      3'd3: r = a ^ b;
      3'd4: r = a + b;
      3'd5: r = (a - b + 256) % 256;
      3'd6: r = a * b;
      default: begin
        if (b == 0) begin r = 255; e.err = 1'b1; end
        else r = a / b;
      end
    endcase
    e.data = r[7:0];
    e.op   = op;
    return e;
  endfunction

  alu_cmd_issuer #(.DEPTH(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cv), .cmd_ready(cr), .cmd_a(ca), .cmd_b(cb), .cmd_op(cop),
    .alu_a(aa), .alu_b(ab), .alu_op(aop), .alu_result(ares),
    .rsp_valid(rv), .rsp_ready(rr), .rsp_data(rd), .rsp_op(ro), .rsp_err(re),
    .busy(busy)
  );

  alu_cmd_issuer #(.DEPTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cv3), .cmd_ready(cr3), .cmd_a(ca3), .cmd_b(cb3), .cmd_op(cop3),
    .alu_a(aa3), .alu_b(ab3), .alu_op(aop3), .alu_result(ares3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_data(rd3), .rsp_op(ro3), .rsp_err(re3),
    .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: scoreboard the handshakes that the coming edge will perform, then
  // advance to 1 time unit after the edge.
  task automatic tick();
    bit         do_push, do_pop, stall, was_rst;
    logic [11:0] held;
    exp_t       e;
    was_rst = rst;
    do_push = !rst && cv && cr;
    do_pop  = !rst && rv && rr;
    if (do_pop) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", rd, e.data);
        chk("rsp_op", ro, e.op);
        chk("rsp_err", re, e.err);
        n_rsp++;
      end
    end
    if (do_push) begin
      exp_q.push_back(make_exp(cop, ca, cb));
      n_acc++;
    end
    stall = !rst && rv && !rr;
    held  = {rd, ro, re};
    @(posedge clk);
    #1;
    if (was_rst) exp_q.delete();
    else if (stall) begin
      chk("stall_valid", rv, 1);
      chk("stall_hold", {rd, ro, re}, held);
    end
    hs_last = do_pop;
  endtask

  task automatic set_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    cop = op; ca = a; cb = b;
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 30 && !rv; i++) tick();
    chk(tag, rv, 1);
  endtask

  task automatic drain(input string tag);
    rr = 1'b1;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || rv); i++) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int acc0, rsp0;
    bit saw_rsp;
    rst = 1'b1;
    cv = 0; ca = 0; cb = 0; cop = 0; rr = 1;
    cv3 = 0; ca3 = 0; cb3 = 0; cop3 = 0; rr3 = 1;
    tick(); tick();
    chk("rst_alu", {aa, ab, aop}, 0);
    chk("rst_rsp", {rv, rd, ro, re}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cr, 1);
    chk("rst3_all", {aa3, ab3, aop3, rv3, rd3, ro3, re3, busy3}, 0);
    rst = 1'b0;
    tick();

    // ADD 9+7 latency: push at edge t, valid after t+3
    cv = 1; set_cmd(3'd4, 4'd9, 4'd7);
    tick();
    cv = 0;
    chk("add_lat_t0", rv, 0);
    tick(); chk("add_lat_t1", rv, 0);
    tick(); chk("add_lat_t2", rv, 0);
    tick(); chk("add_lat_t3", rv, 1);
    chk("add_data", rd, 8'h10);
    chk("add_op", ro, 3'd4);
    chk("add_err", re, 0);
    tick(); chk("add_cleared", rv, 0);

    // divide by zero, then a normal divide
    cv = 1; set_cmd(3'd7, 4'd12, 4'd0); tick(); cv = 0;
    wait_rsp("div0_timeout");
    chk("div0_data", rd, 8'hFF);
    chk("div0_err", re, 1);
    tick();
    chk("div0_err_clr", re, 0);
    cv = 1; set_cmd(3'd7, 4'd12, 4'd3); tick(); cv = 0;
    wait_rsp("div_timeout");
    chk("div_data", rd, 8'h04);
    chk("div_err", re, 0);
    tick();

    // capacity with consumer stalled
    rr = 0;
    acc0 = n_acc; rsp0 = n_rsp;
    for (int i = 0; i < 6; i++) begin
      cv = 1;
      if (i == 0) set_cmd(3'd0, 4'hF, 4'h5);
      else set_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      if (i == 5) chk("cap_ready_low", cr, 0);
      tick();
    end
    tick(); chk("cap_ready_held", cr, 0);
    cv = 0;
    chk("cap_accepted", n_acc - acc0, 5);
    repeat (4) tick();
    chk("cap_first_data", rd, 8'h05);
    chk("cap_first_op", ro, 3'd0);
    drain("cap_drain");
    chk("cap_responses", n_rsp - rsp0, 5);
    chk("cap_ready_back", cr, 1);

    // hold occupancy at two: push only on the cycle the engine pops
    rr = 1;
    for (int i = 0; i < 3; i++) begin
      cv = 1; set_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom)); tick();
    end
    cv = 0;
    for (int i = 0; i < 40; i++) begin
      cv = hs_last;
      set_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      chk("pp_ready", cr, 1);
      tick();
    end
    cv = 0;
    drain("pp_drain");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      cv = 1'($urandom);
      set_cmd(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      rr = ($urandom_range(0, 3) != 0);
      tick();
    end
    cv = 0;
    drain("rand_drain");
    chk("rand_count", n_acc, n_rsp);

    // SETTLE=3: operands held through three DRIVE cycles
    cv3 = 1; ca3 = 4'hF; cb3 = 4'hF; cop3 = 3'd6;
    tick();
    cv3 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s3_alu_hold", {aop3, aa3, ab3}, {3'd6, 4'hF, 4'hF});
      chk("s3_no_rsp", rv3, 0);
    end
    tick(); chk("s3_capture_edge", rv3, 0);
    tick(); chk("s3_valid", rv3, 1);
    chk("s3_data", rd3, 8'hE1);
    chk("s3_op", ro3, 3'd6);
    tick(); chk("s3_cleared", rv3, 0);

    // reset in DRIVE with two queued commands
    for (int i = 0; i < 3; i++) begin
      cv3 = 1; ca3 = 4'(i + 1); cb3 = 4'd1; cop3 = 3'd4; tick();
    end
    cv3 = 0;
    chk("s3_busy_pre_rst", busy3, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s3_rst_outputs", {aa3, ab3, aop3, rv3, rd3, ro3, re3}, 0);
    chk("s3_rst_busy", busy3, 0);
    chk("s3_rst_ready", cr3, 1);
    saw_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rv3 || busy3) saw_rsp = 1;
    end
    chk("s3_no_ghost_rsp", saw_rsp, 0);
    cv3 = 1; ca3 = 4'd5; cb3 = 4'd3; cop3 = 3'd5; tick(); cv3 = 0;
    for (int i = 0; i < 30 && !rv3; i++) tick();
    chk("s3_sub_valid", rv3, 1);
    chk("s3_sub_data", rd3, 8'h02);
    chk("s3_sub_op", ro3, 3'd5);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
